// File: rtl/alu_unit.sv
// alu_unit: registered integer execution unit between the ALU reservation
// station and the CDB arbiter. Single-cycle RV32I/RV64I ALU ops, optional
// iterative shift-add multiplies, and a result held on the CDB until granted.
module alu_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [TAG_W-1:0]  des_i,
  output logic              cdb_en_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  input  logic              cdb_ack_i,
  output logic              busy_o
);

  localparam logic [OP_W-1:0] OP_LUI    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTI   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTIU  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XORI   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ORI    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLLI   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRLI   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SRAI   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(19);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(20);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(21);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(24);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(25);

  localparam int SHW   = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_LUI) && (op <= OP_AND);
  endfunction

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return MUL_EN && (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] pc
  );
    logic signed [DATA_W-1:0] sa, sb, si;
    logic [SHW-1:0] shr, shi;
    logic [DATA_W-1:0] r;
    sa  = a;
    sb  = b;
    si  = imm;
    shr = b[SHW-1:0];
    shi = imm[SHW-1:0];
    case (op)
      OP_LUI:   r = imm;
      OP_AUIPC: r = pc + imm;
      OP_ADDI:  r = a + imm;
      OP_SLTI:  r = DATA_W'(sa < si);
      OP_SLTIU: r = DATA_W'(a < imm);
      OP_XORI:  r = a ^ imm;
      OP_ORI:   r = a | imm;
      OP_ANDI:  r = a & imm;
      OP_SLLI:  r = a << shi;
      OP_SRLI:  r = a >> shi;
      OP_SRAI:  r = sa >>> shi;
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_SLL:   r = a << shr;
      OP_SLT:   r = DATA_W'(sa < sb);
      OP_SLTU:  r = DATA_W'(a < b);
      OP_XOR:   r = a ^ b;
      OP_SRL:   r = a >> shr;
      OP_SRA:   r = sa >>> shr;
      OP_OR:    r = a | b;
      OP_AND:   r = a & b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic                  hi_q, hi_d;
  logic [TAG_W-1:0]      mtag_q, mtag_d;
  logic                  en_q, en_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic                  accept, launch, s1neg, s2neg;
  logic [2*DATA_W-1:0]   acc_step, prod;

  assign in_ready_o = !rst_in && !flush_in && rdy_in &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && cdb_ack_i));
  assign accept     = in_valid_i && in_ready_o;
  assign cdb_en_o   = en_q;
  assign cdb_tag_o  = tag_q;
  assign cdb_data_o = data_q;
  assign busy_o     = (state_q != S_IDLE);

  // Next-state logic: flush over freeze over normal issue/iterate/ack handling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    mtag_d   = mtag_q;
    en_d     = en_q;
    tag_d    = tag_q;
    data_d   = data_q;
    launch   = 1'b0;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod     = neg_q ? -acc_step : acc_step;
    s1neg    = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && reg1_i[DATA_W-1];
    s2neg    = (op_i == OP_MULH) && reg2_i[DATA_W-1];

    if (flush_in) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      en_d    = 1'b0;
    end else if (rdy_in) begin
      case (state_q)
        S_IDLE: launch = accept;
        S_MUL: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            en_d    = 1'b1;
            tag_d   = mtag_q;
            data_d  = hi_q ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
          end
        end
        S_DONE: begin
          if (cdb_ack_i) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            launch  = accept;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (launch) begin
        if (is_mul_op(op_i)) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          mcand_d  = {{DATA_W{1'b0}}, mag(reg1_i, s1neg)};
          mplier_d = mag(reg2_i, s2neg);
          acc_d    = '0;
          neg_d    = s1neg ^ s2neg;
          hi_d     = (op_i != OP_MUL);
          mtag_d   = des_i;
        end else if (is_alu_op(op_i)) begin
          state_d = S_DONE;
          en_d    = 1'b1;
          tag_d   = des_i;
          data_d  = alu_calc(op_i, reg1_i, reg2_i, imm_i, pc_i);
        end else begin
          state_d = S_IDLE;
          en_d    = 1'b0;
        end
      end
    end
  end

  // State register; reset clears every flop.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      mtag_q   <= '0;
      en_q     <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      mtag_q   <= mtag_d;
      en_q     <= en_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit (DATA_W=32): directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_alu_unit;

  localparam logic [5:0] LUI = 6'd1, AUIPC = 6'd2, ADDI = 6'd3, SLTI = 6'd4,
    SLTIU = 6'd5, XORI = 6'd6, ORI = 6'd7, ANDI = 6'd8, SLLI = 6'd9, SRLI = 6'd10,
    SRAI = 6'd11, ADD = 6'd12, SUB = 6'd13, SLL = 6'd14, SLT = 6'd15, SLTU = 6'd16,
    XOR = 6'd17, SRL = 6'd18, SRA = 6'd19, OR = 6'd20, AND = 6'd21, MUL = 6'd22,
    MULH = 6'd23, MULHSU = 6'd24, MULHU = 6'd25, UNK = 6'd63;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, valid, ack, v0;
  logic [5:0]  op;
  logic [31:0] r1, r2, imm, pc;
  logic [3:0]  des;
  logic        ready, en, busy, ready0, en0, busy0;
  logic [3:0]  tag, tag0;
  logic [31:0] data, data0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_unit #(.DATA_W(32), .TAG_W(4), .OP_W(6), .MUL_EN(1'b1)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .in_valid_i(valid), .in_ready_o(ready), .op_i(op), .reg1_i(r1), .reg2_i(r2),
    .imm_i(imm), .pc_i(pc), .des_i(des), .cdb_en_o(en), .cdb_tag_o(tag),
    .cdb_data_o(data), .cdb_ack_i(ack), .busy_o(busy));

  alu_unit #(.DATA_W(32), .TAG_W(4), .OP_W(6), .MUL_EN(1'b0)) dut0 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .in_valid_i(v0), .in_ready_o(ready0), .op_i(op), .reg1_i(r1), .reg2_i(r2),
    .imm_i(imm), .pc_i(pc), .des_i(des), .cdb_en_o(en0), .cdb_tag_o(tag0),
    .cdb_data_o(data0), .cdb_ack_i(1'b1), .busy_o(busy0));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_mul(input logic [5:0] o);
    return (o >= MUL) && (o <= MULHU);
  endfunction

  // Reference model from the arithmetic definitions of each operation.
  function automatic logic [31:0] ref_result(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] i,
                                             input logic [31:0] p);
    longint sa, sb, si, sp;
    logic [63:0] ua, ub, prod;
    int shb, shi;
    sa = longint'($signed(a)); sb = longint'($signed(b)); si = longint'($signed(i));
    ua = {32'd0, a}; ub = {32'd0, b};
    shb = int'(b % 32); shi = int'(i % 32);
    sp = 0;
    prod = 64'd0;
    case (o)
      LUI:    return i;
      AUIPC:  return 32'((64'(p) + 64'(i)) % 64'h1_0000_0000);
      ADDI:   return 32'(sa + si);
      SLTI:   return (sa < si) ? 32'd1 : 32'd0;
      SLTIU:  return (a < i) ? 32'd1 : 32'd0;
      XORI:   return a ^ i;
      ORI:    return a | i;
      ANDI:   return a & i;
      SLLI:   return 32'(ua * (64'd1 << shi));
      SRLI:   return 32'(ua / (64'd1 << shi));
      SRAI:   begin sp = sa / (longint'(1) << shi);
                    if (sa < 0 && (sa % (longint'(1) << shi)) != 0) sp = sp - 1;
                    return 32'(sp); end
      ADD:    return 32'(sa + sb);
      SUB:    return 32'(sa - sb);
      SLL:    return 32'(ua * (64'd1 << shb));
      SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      SLTU:   return (a < b) ? 32'd1 : 32'd0;
      XOR:    return a ^ b;
      SRL:    return 32'(ua / (64'd1 << shb));
      SRA:    begin sp = sa / (longint'(1) << shb);
                    if (sa < 0 && (sa % (longint'(1) << shb)) != 0) sp = sp - 1;
                    return 32'(sp); end
      OR:     return a | b;
      AND:    return a & b;
      MUL:    begin prod = ua * ub; return prod[31:0]; end
      MULH:   begin prod = 64'(sa * sb); return prod[63:32]; end
      MULHSU: begin prod = 64'(sa * longint'(ub)); return prod[63:32]; end
      MULHU:  begin prod = ua * ub; return prod[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op from IDLE, measure latency, hold the result `hold` cycles, then ack.
  task automatic run_op(input string name, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] i, input logic [31:0] p,
                        input logic [3:0] d, input int hold);
    int cycles;
    logic [31:0] exp;
    exp = ref_result(o, a, b, i, p);
    valid = 1'b1; op = o; r1 = a; r2 = b; imm = i; pc = p; des = d; ack = 1'b0;
    #1 chk({name, "_ready"}, 64'(ready), 64'd1);
    step();
    valid = 1'b0;
    cycles = 1;
    while (en !== 1'b1 && cycles < 60) begin
      step();
      cycles++;
    end
    chk({name, "_latency"}, 64'(cycles), is_mul(o) ? 64'd33 : 64'd1);
    chk({name, "_tag"}, 64'(tag), 64'(d));
    chk({name, "_data"}, 64'(data), 64'(exp));
    for (int k = 0; k < hold; k++) begin
      step();
      chk({name, "_hold_en"}, 64'(en), 64'd1);
      chk({name, "_hold_tag"}, 64'(tag), 64'(d));
      chk({name, "_hold_data"}, 64'(data), 64'(exp));
      chk({name, "_hold_ready"}, 64'(ready), 64'd0);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk({name, "_post_en"}, 64'(en), 64'd0);
    chk({name, "_post_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cycles;
    bit seen;
    logic [5:0] ro;
    logic [31:0] ra, rb, ri, rp;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; valid = 1'b1; v0 = 1'b0; ack = 1'b0;
    op = ADD; r1 = 32'd1; r2 = 32'd2; imm = 32'd0; pc = 32'd0; des = 4'd1;

    // Reset state
    step();
    step();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_tag", 64'(tag), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    valid = 1'b0;
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(ready), 64'd1);

    // Directed ALU ops
    run_op("add", ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 0);
    run_op("sra", SRA, 32'h8000_0000, 32'h3F, 32'd0, 32'd0, 4'd4, 0);
    run_op("sltu", SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd5, 0);
    run_op("slt", SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd6, 0);
    run_op("auipc", AUIPC, 32'd0, 32'd0, 32'h0000_1000, 32'hFFFF_F800, 4'd7, 0);
    run_op("addi_hold", ADDI, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'd8, 3);

    // Back-to-back single-cycle ops with ack held high
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        chk("b2b_en", 64'(en), 64'd1);
        chk("b2b_tag", 64'(tag), 64'(k - 1));
        chk("b2b_data", 64'(data), 64'(ref_result(ADDI, 32'(k * 100 - 100), 32'd0, 32'(k - 1), 32'd0)));
      end
      valid = 1'b1; op = ADDI; r1 = 32'(k * 100); imm = 32'(k); des = 4'(k);
      #1 chk("b2b_ready", 64'(ready), 64'd1);
      step();
    end
    valid = 1'b0;
    chk("b2b_last_data", 64'(data), 64'd303);
    step();
    chk("b2b_idle_en", 64'(en), 64'd0);
    ack = 1'b0;

    // Multiplies
    run_op("mulh", MULH, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'd0, 4'd9, 0);
    chk("mulh_const", 64'(data), 64'hFFFF_FFFF);
    run_op("mul", MUL, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'd0, 4'd10, 0);
    chk("mul_const", 64'(data), 64'hFFFF_FFFA);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd11, 1);
    chk("mulhu_const", 64'(data), 64'hFFFF_FFFE);
    run_op("mulhsu", MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd12, 0);

    // Flush mid-multiply
    valid = 1'b1; op = MUL; r1 = 32'd9; r2 = 32'd9; des = 4'd13;
    step();
    valid = 1'b0;
    repeat (10) step();
    flush = 1'b1; valid = 1'b1; op = ADD;
    #1 chk("flush_ready", 64'(ready), 64'd0);
    step();
    flush = 1'b0; valid = 1'b0;
    chk("flush_en", 64'(en), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (30) begin
      step();
      if (en === 1'b1) seen = 1'b1;
    end
    chk("flush_no_bcast", 64'(seen), 64'd0);
    run_op("add_after_flush", ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 4'd14, 0);

    // Unknown op consumed without a broadcast
    valid = 1'b1; op = UNK; des = 4'd2;
    #1 chk("unk_ready", 64'(ready), 64'd1);
    step();
    valid = 1'b0;
    chk("unk_en", 64'(en), 64'd0);
    chk("unk_busy", 64'(busy), 64'd0);

    // Multiply on the MUL_EN=0 instance is an unknown op
    v0 = 1'b1; op = MUL; r1 = 32'd3; r2 = 32'd4;
    #1 chk("nomul_ready", 64'(ready0), 64'd1);
    step();
    v0 = 1'b0;
    chk("nomul_en", 64'(en0), 64'd0);
    chk("nomul_busy", 64'(busy0), 64'd0);

    // Freeze mid-multiply extends latency, and a frozen ack is not consumed
    valid = 1'b1; op = MULHU; r1 = 32'h1234_5678; r2 = 32'h9ABC_DEF0; des = 4'd15;
    step();
    valid = 1'b0;
    cycles = 1;
    repeat (5) begin step(); cycles++; end
    rdy = 1'b0;
    repeat (5) begin step(); cycles++; end
    chk("stall_busy", 64'(busy), 64'd1);
    rdy = 1'b1;
    while (en !== 1'b1 && cycles < 80) begin step(); cycles++; end
    chk("stall_latency", 64'(cycles), 64'd38);
    chk("stall_data", 64'(data), 64'(ref_result(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0)));
    ack = 1'b1; rdy = 1'b0;
    #1 chk("stall_ack_ready", 64'(ready), 64'd0);
    step();
    chk("stall_ack_held", 64'(en), 64'd1);
    rdy = 1'b1;
    step();
    ack = 1'b0;
    chk("stall_ack_taken", 64'(en), 64'd0);

    // Randomized ops against the reference model
    for (int k = 0; k < 25; k++) begin
      ro = 6'($urandom_range(1, 25));
      ra = $urandom; rb = $urandom; ri = $urandom; rp = $urandom;
      if (k % 3 == 0) ra = 32'h8000_0000 | ra;
      run_op("rand", ro, ra, rb, ri, rp, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    // Reset mid-multiply zeroes the result registers
    valid = 1'b1; op = MUL; r1 = 32'd7; r2 = 32'd6; des = 4'd9;
    step();
    valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mul_en", 64'(en), 64'd0);
    chk("rst_mul_tag", 64'(tag), 64'd0);
    chk("rst_mul_data", 64'(data), 64'd0);
    chk("rst_mul_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
